main_memory_banked: RTL and testbench
=====================================

// Module: main_memory_banked
// PURPOSE
//  Parametrised banked main memory with a valid/ready request/response handshake.
//  Serves whole-line reads and byte-granular writes for ICACHE/DCACHE fill and writeback traffic.
//  Banks are selected by the top address bits. Access latency is programmable.
//  Sits behind the cache miss path; one request in flight at a time.
// PARAMETERS
//  ADDR_W    15   byte address width
//  LINE_W    128  line width in bits; must be a power of 2, >= 32
//  BANKS     2    number of banks; power of 2; bank = ADDR[ADDR_W-1 -: log2(BANKS)]
//  LATENCY   3    cycles from request accept to RSP_VALID; >= 1
// PORTS
//  CLK        in   1             clock; all state updates on rising edge
//  CLR        in   1             synchronous reset, active low
//  REQ_VALID  in   1             request present
//  REQ_READY  out  1             block can accept a request
//  REQ_ADDR   in   ADDR_W        byte address
//  REQ_WR     in   1             1 = write, 0 = line read
//  REQ_SIZE   in   2             write size: 0 = 1B, 1 = 2B, 2 = 4B, 3 = reserved
//  REQ_SRC    in   2             requester tag; echoed on the response
//  REQ_WDATA  in   32            write data, right-aligned
//  RSP_VALID  out  1             response present
//  RSP_READY  in   1             consumer accepts the response
//  RSP_SRC    out  2             echoed REQ_SRC
//  RSP_DATA   out  LINE_W        read: aligned line containing REQ_ADDR; write: all zeros
//  RSP_ERR    out  1             request rejected (see below); no state change
// BEHAVIOUR
//  - Reset: FSM -> IDLE; REQ_READY=1; RSP_VALID=0, RSP_SRC=0, RSP_DATA=0, RSP_ERR=0; latency counter=0.
//    Array contents are retained unless MAIN_MEM_INIT_EN is defined.
//  - Geometry: line index = ADDR[ADDR_W-log2(BANKS)-1 : log2(LINE_W/8)]; byte offset = low bits.
//  - FSM IDLE -> BUSY on REQ_VALID & REQ_READY. Address, wr, size, src and wdata are captured that cycle.
//    REQ_READY is 0 outside IDLE.
//  - BUSY: the counter loads LATENCY-1 on accept and decrements each cycle.
//    At 0: reads latch the line, writes commit the byte enables; FSM -> RESP with RSP_VALID=1.
//    Result: RSP_VALID rises exactly LATENCY cycles after the accept edge.
//  - RESP: outputs are held stable while RSP_READY=0. When RSP_VALID & RSP_READY: FSM -> IDLE and REQ_READY=1
//    on the next cycle (no same-cycle re-accept). RSP_DATA keeps its last value after the handshake.
//  - Write byte enables: (1<<bytes)-1 shifted by the byte offset; WDATA byte i goes to line byte offset+i.
//  - Error: REQ_SIZE=3, or a write whose offset+bytes exceeds LINE_W/8.
//    Response: RSP_ERR=1, RSP_DATA=0, array untouched, same LATENCY. RSP_ERR=0 on every good response.
//  - A write response carries RSP_DATA=0. A read after a write to the same line returns the new data.
//  - CLR low mid-operation: the in-flight request is dropped; a pending write is not committed if CLR is low at the commit edge.
//  - Address bits above ADDR_W do not exist. A top bank bit that selects a nonexistent bank cannot occur (BANKS is a power of 2).
// CONFIGURATION
//  MAIN_MEM_INIT_EN defined: after CLR deasserts, FSM enters INIT and writes zero to one line per cycle.
//    The sweep runs over all banks in parallel, index 0..depth-1. REQ_READY=0 during INIT.
//    IDLE is entered after the last index. CLR low during INIT restarts the sweep at index 0.
//  MAIN_MEM_INIT_EN undefined: no INIT state. IDLE directly after reset; the array is uninitialised (X in sim).
// TESTING
//  1 Reset: CLR=0 for 2 cycles -> REQ_READY=1, RSP_VALID=0, RSP_ERR=0, RSP_DATA=0.
//  2 Write 4B 0xDEADBEEF @0x0010, then read @0x001C -> RSP_DATA[31:0]=0xDEADBEEF, RSP_VALID exactly 3 cycles after each accept.
//  3 Bank split: write 1B 0xA5 @0x4003 and 1B 0x5A @0x0003, then read 0x4000 -> RSP_DATA[31:24]=0xA5;
//    read 0x0000 -> RSP_DATA[31:24]=0x5A.
//  4 Backpressure: hold RSP_READY=0 for 5 cycles -> RSP_VALID/RSP_DATA/RSP_SRC stable, REQ_READY=0;
//    after the handshake, REQ_READY=1 on the next cycle.
//  5 Error: 4B write @0x000E -> RSP_ERR=1, RSP_DATA=0; a later read of line 0x0000 is unchanged. REQ_SIZE=3 -> RSP_ERR=1.
//  6 INIT_EN build: after reset, REQ_READY=0 for depth cycles; any read then returns all zeros. Pulse CLR mid-sweep -> sweep restarts.

Source files
------------

// File: rtl/main_memory_banked.sv
// main_memory_banked: banked line memory sitting behind the cache miss path.
// One request in flight; whole-line reads, 1/2/4-byte writes, fixed LATENCY.
// Bank = top address bits, so the flat array index {bank, line index} is
// simply the byte address with the in-line offset dropped.
// Build option: define MAIN_MEM_INIT_EN to zero every line after reset
// (INIT sweep over all banks in parallel); otherwise contents are uninitialised.
//
// state  | meaning
// S_IDLE | ready for a request (req_ready = 1)
// S_BUSY | request captured, latency counter running down to 0
// S_RESP | response presented, held until rsp_ready
// S_INIT | (MAIN_MEM_INIT_EN only) zero sweep, one line index per cycle
module main_memory_banked #(
    parameter int ADDR_W  = 15,
    parameter int LINE_W  = 128,
    parameter int BANKS   = 2,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic [1:0]        req_src,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_src,
    output logic [LINE_W-1:0] rsp_data,
    output logic              rsp_err
);
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int BANK_W     = $clog2(BANKS);
    localparam int IDX_W      = ADDR_W - BANK_W - OFF_W;
    localparam int DEPTH      = 1 << IDX_W;
    localparam int LA_W       = ADDR_W - OFF_W;
    localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int SPAN_W     = OFF_W + 3;

`ifdef MAIN_MEM_INIT_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_INIT} state_t;
    logic [IDX_W-1:0] init_idx;
`else
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
`endif

    state_t state;

    logic [LINE_W-1:0] mem [BANKS*DEPTH];

    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [1:0]        src_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  cnt;

    logic [LA_W-1:0]       line_q;
    logic [OFF_W-1:0]      off_q;
    logic [2:0]            nbytes;
    logic [SPAN_W-1:0]     span;
    logic                  bad_req;
    logic                  commit;
    logic [LINE_BYTES-1:0] be;
    logic [LINE_W-1:0]     wline;

    // decode of the captured request: geometry, size, error, byte lanes
    always_comb begin
        line_q  = addr_q[ADDR_W-1:OFF_W];
        off_q   = addr_q[OFF_W-1:0];
        nbytes  = (size_q == 2'd0) ? 3'd1 : (size_q == 2'd1) ? 3'd2 : 3'd4;
        span    = SPAN_W'(off_q) + SPAN_W'(nbytes);
        bad_req = (size_q == 2'd3) || (wr_q && (span > SPAN_W'(LINE_BYTES)));
        commit  = (state == S_BUSY) && (cnt == '0);
        be      = LINE_BYTES'((5'd1 << nbytes) - 5'd1) << off_q;
        wline   = LINE_W'(wdata_q) << {off_q, 3'b000};
    end

    // array writes; nothing lands while clr is low, so a reset at the
    // commit edge drops the pending write
    always_ff @(posedge clk) begin
        if (clr) begin
            if (commit && wr_q && !bad_req) begin
                for (int i = 0; i < LINE_BYTES; i++) begin
                    if (be[i]) mem[line_q][i*8 +: 8] <= wline[i*8 +: 8];
                end
            end
`ifdef MAIN_MEM_INIT_EN
            if (state == S_INIT) begin
                for (int b = 0; b < BANKS; b++) begin
                    mem[(LA_W'(b) << IDX_W) | LA_W'(init_idx)] <= '0;
                end
            end
`endif
        end
    end

    // request/response FSM with registered handshake and response outputs
    always_ff @(posedge clk) begin
        if (!clr) begin
`ifdef MAIN_MEM_INIT_EN
            state     <= S_INIT;
            req_ready <= 1'b0;
            init_idx  <= '0;
`else
            state     <= S_IDLE;
            req_ready <= 1'b1;
`endif
            rsp_valid <= 1'b0;
            rsp_src   <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            size_q    <= '0;
            src_q     <= '0;
            wdata_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        wr_q      <= req_wr;
                        size_q    <= req_size;
                        src_q     <= req_src;
                        wdata_q   <= req_wdata;
                        cnt       <= CNT_W'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt == '0) begin
                        rsp_valid <= 1'b1;
                        rsp_src   <= src_q;
                        rsp_err   <= bad_req;
                        rsp_data  <= (wr_q || bad_req) ? '0 : mem[line_q];
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
`ifdef MAIN_MEM_INIT_EN
                S_INIT: begin
                    if (init_idx == '1) begin
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        init_idx <= init_idx + IDX_W'(1);
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_main_memory_banked.sv
// Bench for main_memory_banked: directed vector table, reset-at-commit
// sequence and randomized traffic against a byte-addressed reference memory.
module tb_main_memory_banked;
    localparam int ADDR_W     = 15;
    localparam int LINE_W     = 128;
    localparam int BANKS      = 2;
    localparam int LATENCY    = 3;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int DEPTH      = (1 << ADDR_W) / BANKS / LINE_BYTES;

    logic              clk = 1'b0;
    logic              clr;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wr;
    logic [1:0]        req_size;
    logic [1:0]        req_src;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_src;
    logic [LINE_W-1:0] rsp_data;
    logic              rsp_err;

    int checks   = 0;
    int failures = 0;

    byte unsigned mm[int];
    bit           model_zero = 1'b0;

    main_memory_banked #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .BANKS(BANKS), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wr(req_wr), .req_size(req_size), .req_src(req_src), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic bit model_err(input int a, input bit wr, input int sz);
        return (sz == 3) || (wr && ((a % LINE_BYTES) + (1 << sz) > LINE_BYTES));
    endfunction

    function automatic void model_line(input int a, output logic [LINE_W-1:0] d,
                                       output logic [LINE_W-1:0] m);
        int base;
        base = a - (a % LINE_BYTES);
        d = '0;
        m = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (mm.exists(base + i)) begin
                d[i*8 +: 8] = mm[base + i];
                m[i*8 +: 8] = 8'hFF;
            end else if (model_zero) begin
                m[i*8 +: 8] = 8'hFF;
            end
        end
    endfunction

    function automatic void model_write(input int a, input int sz, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) mm[a + i] = wd[i*8 +: 8];
    endfunction

    function automatic void model_reset();
`ifdef MAIN_MEM_INIT_EN
        mm.delete();
        model_zero = 1'b1;
`endif
    endfunction

    // one full transaction; all timing is relative to "#1 after a rising edge"
    task automatic do_req(input int a, input bit wr, input int sz, input logic [1:0] src,
                          input logic [31:0] wd, input int hold,
                          output logic [LINE_W-1:0] got, output logic got_err);
        int n;
        bit exp_err;
        logic [LINE_W-1:0] exp_d, mask;
        exp_err = model_err(a, wr, sz);
        model_line(a, exp_d, mask);
        if (wr || exp_err) begin
            exp_d = '0;
            mask  = '1;
        end
        n = 0;
        while (req_ready !== 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_wait", (n < 5000), 1'b1);
        req_valid = 1'b1;
        req_addr  = ADDR_W'(a);
        req_wr    = wr;
        req_size  = 2'(sz);
        req_src   = src;
        req_wdata = wd;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = ADDR_W'($urandom);
        req_wdata = $urandom;
        req_size  = 2'($urandom);
        chk("ready_low_after_accept", req_ready, 1'b0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (rsp_valid !== 1'b1 && n < 20);
        chk("latency", n, LATENCY);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_src", rsp_src, src);
        chk("rsp_data", rsp_data & mask, exp_d & mask);
        got     = rsp_data;
        got_err = rsp_err;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_stable", {rsp_valid, rsp_src, rsp_err, rsp_data, req_ready},
                {1'b1, src, exp_err, got, 1'b0});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("after_handshake", {rsp_valid, req_ready}, 2'b01);
        chk("data_kept", rsp_data, got);
        if (wr && !exp_err) model_write(a, sz, wd);
    endtask

    typedef struct {
        int          addr;
        bit          wr;
        int          size;
        logic [1:0]  src;
        logic [31:0] wdata;
        int          hold;
        bit          exp_err;
        int          word;
        logic [31:0] mask;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [LINE_W-1:0] got;
        logic              gerr;
        int                a, ln, sz, n;
        bit                wr;

        vecs.push_back('{'h0010, 1, 2, 2'd1, 32'hDEADBEEF, 0, 0, 0, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{'h001C, 0, 0, 2'd2, 32'h0,        0, 0, 0, 32'hFFFFFFFF, 32'hDEADBEEF});
        vecs.push_back('{'h4003, 1, 0, 2'd3, 32'h000000A5, 0, 0, 0, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{'h0003, 1, 0, 2'd0, 32'h0000005A, 0, 0, 0, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{'h4000, 0, 0, 2'd1, 32'h0,        0, 0, 0, 32'hFF000000, 32'hA5000000});
        vecs.push_back('{'h0000, 0, 0, 2'd2, 32'h0,        5, 0, 0, 32'hFF000000, 32'h5A000000});
        vecs.push_back('{'h000C, 1, 2, 2'd3, 32'h01020304, 0, 0, 0, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{'h000E, 1, 2, 2'd1, 32'hCAFEF00D, 0, 1, 0, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{'h0000, 0, 0, 2'd0, 32'h0,        0, 0, 3, 32'hFFFFFFFF, 32'h01020304});
        vecs.push_back('{'h0020, 1, 3, 2'd2, 32'h12345678, 0, 1, 0, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{'h000F, 1, 1, 2'd3, 32'h0000BEEF, 0, 1, 0, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{'h4006, 1, 1, 2'd1, 32'h00007788, 5, 0, 0, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{'h4004, 0, 0, 2'd2, 32'h0,        3, 0, 1, 32'hFFFF0000, 32'h77880000});
        vecs.push_back('{'h000F, 1, 0, 2'd0, 32'h00000033, 0, 0, 0, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{'h0008, 0, 0, 2'd1, 32'h0,        0, 0, 3, 32'hFFFFFFFF, 32'h33020304});

        clr = 1'b0; req_valid = 1'b0; req_addr = '0; req_wr = 1'b0;
        req_size = '0; req_src = '0; req_wdata = '0; rsp_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
`ifdef MAIN_MEM_INIT_EN
        chk("reset_req_ready", req_ready, 1'b0);
`else
        chk("reset_req_ready", req_ready, 1'b1);
`endif
        chk("reset_rsp", {rsp_valid, rsp_err, rsp_src}, 4'b0);
        chk("reset_rsp_data", rsp_data, '0);
        clr = 1'b1;

`ifdef MAIN_MEM_INIT_EN
        repeat (100) @(posedge clk);
        #1;
        chk("init_ready_mid_sweep", req_ready, 1'b0);
        clr = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (req_ready !== 1'b1 && n < 3 * DEPTH);
        chk("init_sweep_cycles", n, DEPTH);
        do_req('h4010, 0, 0, 2'd1, 32'h0, 0, got, gerr);
        chk("init_read_zero", got, '0);
`endif

        foreach (vecs[i]) begin
            do_req(vecs[i].addr, vecs[i].wr, vecs[i].size, vecs[i].src, vecs[i].wdata,
                   vecs[i].hold, got, gerr);
            chk($sformatf("vec%0d_err", i), gerr, vecs[i].exp_err);
            chk($sformatf("vec%0d_word", i), got[vecs[i].word*32 +: 32] & vecs[i].mask,
                vecs[i].exp_word);
        end

        // reset asserted at the commit edge of a write: request dropped, no commit
        while (req_ready !== 1'b1) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_addr = 15'h000C; req_wr = 1'b1; req_size = 2'd2;
        req_src = 2'd3; req_wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (LATENCY - 1) @(posedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        model_reset();
        chk("drop_rsp_valid", {rsp_valid, rsp_err}, 2'b00);
`ifndef MAIN_MEM_INIT_EN
        chk("drop_req_ready", req_ready, 1'b1);
`endif
        do_req('h000C, 0, 0, 2'd0, 32'h0, 0, got, gerr);
`ifndef MAIN_MEM_INIT_EN
        chk("drop_no_commit", got[127:96], 32'h33020304);
`endif

        // randomized traffic over 8 lines (4 per bank), preloaded so every byte is known
        for (int l = 0; l < 8; l++) begin
            for (int w = 0; w < 4; w++) begin
                a = ((l / 4) << 14) | 'h200 | ((l % 4) << 4) | (w * 4);
                do_req(a, 1'b1, 2, 2'($urandom), $urandom, 0, got, gerr);
            end
        end
        for (int t = 0; t < 60; t++) begin
            ln = $urandom_range(0, 7);
            a  = ((ln / 4) << 14) | 'h200 | ((ln % 4) << 4) | $urandom_range(0, 15);
            wr = 1'($urandom_range(0, 1));
            sz = wr ? $urandom_range(0, 3) : $urandom_range(0, 2);
            do_req(a, wr, sz, 2'($urandom), $urandom, $urandom_range(0, 2), got, gerr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
